// File: rtl/nq_defs_pkg.sv
// Shared NaughtyQ definitions: command encoding and controller state type.
package nq_defs;

  localparam int NQ_COMMAND_WIDTH = 1;

  typedef enum logic [NQ_COMMAND_WIDTH:0] {
    NQ_NOP        = 2'd0,
    NQ_ENLIST     = 2'd1,
    NQ_BACKOFQUEU = 2'd2,
    NQ_READDATA   = 2'd3
  } nq_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAM,
    S_ISSUE,
    S_RELEASE,
    S_RESPOND,
    S_ERROR
  } nq_state_e;

endpackage

// File: rtl/nq_tag_cam.sv
// Tag table: one key + valid bit per queue index, fully associative compare.
module nq_tag_cam #(
  parameter int IDX_WIDTH = 3,
  parameter int KEY_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_wr_en,
  input  logic [IDX_WIDTH-1:0]      i_wr_idx,
  input  logic [KEY_WIDTH-1:0]      i_wr_key,
  input  logic                      i_wr_valid,
  input  logic [KEY_WIDTH-1:0]      i_cmp_key,
  output logic                      o_match,
  output logic [IDX_WIDTH-1:0]      o_hit_idx,
  output logic [(1<<IDX_WIDTH)-1:0] o_valid
);
  localparam int N = 1 << IDX_WIDTH;

  logic [N-1:0]                r_valid;
  logic [N-1:0][KEY_WIDTH-1:0] r_keys;
  logic [N-1:0]                w_eq;

  for (genvar g = 0; g < N; g++) begin : g_cmp
    assign w_eq[g] = r_valid[g] && (r_keys[g] == i_cmp_key);
  end

  // Lowest index wins, although a key is never held twice.
  always_comb begin
    o_hit_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_eq[i]) o_hit_idx = IDX_WIDTH'(i);
    end
  end

  assign o_match = |w_eq;
  assign o_valid = r_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
      r_keys  <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= i_wr_valid;
      if (i_wr_valid) r_keys[i_wr_idx] <= i_wr_key;
    end
  end

endmodule

// File: rtl/nq_lru_controller.sv
// LRU key/value cache controller that sequences commands into one NaughtyQ.
module nq_lru_controller
  import nq_defs::*;
#(
  parameter int IDX_WIDTH   = 3,
  parameter int KEY_WIDTH   = 8,
  parameter int VALUE_WIDTH = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_op,
  input  logic [KEY_WIDTH-1:0]             req_key,
  input  logic [VALUE_WIDTH-1:0]           req_value,
  output logic                             resp_valid,
  output logic                             resp_hit,
  output logic [VALUE_WIDTH-1:0]           resp_value,
  output logic [IDX_WIDTH-1:0]             resp_idx,
  output logic                             resp_evict_valid,
  output logic [KEY_WIDTH-1:0]             resp_evict_key,
  output logic [VALUE_WIDTH-1:0]           resp_evict_value,
  output logic                             error,
  output logic [NQ_COMMAND_WIDTH:0]        nq_command,
  output logic                             nq_enable,
  output logic [IDX_WIDTH-1:0]             nq_idx,
  output logic [KEY_WIDTH+VALUE_WIDTH-1:0] nq_data,
  input  logic                             nq_ready,
  input  logic                             nq_crashed,
  input  logic [IDX_WIDTH-1:0]             nq_idx_ret,
  input  logic [KEY_WIDTH+VALUE_WIDTH-1:0] nq_data_ret
);
  localparam int N   = 1 << IDX_WIDTH;
  localparam int DW  = KEY_WIDTH + VALUE_WIDTH;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  // Queue data packing: key in the MSBs, value in the LSBs.
  localparam int KEY_LSB = VALUE_WIDTH;
  localparam int KEY_MSB = DW - 1;
  localparam int VAL_MSB = VALUE_WIDTH - 1;

  nq_state_e              r_state;
  nq_cmd_e                r_step;
  nq_cmd_e                r_cmd;
  logic                   r_op;
  logic [KEY_WIDTH-1:0]   r_key;
  logic [VALUE_WIDTH-1:0] r_value;
  logic [WDW-1:0]         r_wd;
  logic [IDX_WIDTH-1:0]   r_hit_idx;
  logic                   r_lu_hit;
  logic                   r_evict_v;
  logic [IDX_WIDTH-1:0]   r_ret_idx;
  logic [DW-1:0]          r_ret_data;
  logic                   r_enable;
  logic [IDX_WIDTH-1:0]   r_nq_idx;
  logic [DW-1:0]          r_nq_data;
  logic                   r_error;
  logic                   r_resp_valid;
  logic                   r_resp_hit;
  logic [VALUE_WIDTH-1:0] r_resp_value;
  logic [IDX_WIDTH-1:0]   r_resp_idx;
  logic                   r_resp_ev;
  logic [KEY_WIDTH-1:0]   r_resp_ek;
  logic [VALUE_WIDTH-1:0] r_resp_evv;

  logic                   w_accept;
  logic [KEY_WIDTH-1:0]   w_cam_key;
  logic                   w_match;
  logic [IDX_WIDTH-1:0]   w_hit_idx;
  logic [N-1:0]           w_valid;
  logic                   w_wr_en;
  logic [IDX_WIDTH-1:0]   w_wr_idx;
  logic [KEY_WIDTH-1:0]   w_wr_key;
  logic                   w_wr_valid;
  logic                   w_enlist_done;

  assign req_ready = (r_state == S_IDLE) && !r_error && !reset;
  assign w_accept  = req_valid && req_ready && !nq_crashed;
  // In IDLE the CAM looks at the incoming key so a re-insert can drop its old tag on accept.
  assign w_cam_key = (r_state == S_IDLE) ? req_key : r_key;
  assign w_enlist_done = (r_state == S_ISSUE) && nq_ready && !nq_crashed && (r_step == NQ_ENLIST);

  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_idx   = '0;
    w_wr_key   = '0;
    w_wr_valid = 1'b0;
    if (w_accept && req_op && w_match) begin
      w_wr_en  = 1'b1;
      w_wr_idx = w_hit_idx;
      w_wr_key = req_key;
    end else if (w_enlist_done) begin
      w_wr_en    = 1'b1;
      w_wr_idx   = nq_idx_ret;
      w_wr_key   = r_key;
      w_wr_valid = 1'b1;
    end
  end

  nq_tag_cam #(
    .IDX_WIDTH (IDX_WIDTH),
    .KEY_WIDTH (KEY_WIDTH)
  ) u_cam (
    .clock      (clock),
    .reset      (reset),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (w_wr_idx),
    .i_wr_key   (w_wr_key),
    .i_wr_valid (w_wr_valid),
    .i_cmp_key  (w_cam_key),
    .o_match    (w_match),
    .o_hit_idx  (w_hit_idx),
    .o_valid    (w_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_step       <= NQ_NOP;
      r_cmd        <= NQ_NOP;
      r_op         <= 1'b0;
      r_key        <= '0;
      r_value      <= '0;
      r_wd         <= '0;
      r_hit_idx    <= '0;
      r_lu_hit     <= 1'b0;
      r_evict_v    <= 1'b0;
      r_ret_idx    <= '0;
      r_ret_data   <= '0;
      r_enable     <= 1'b0;
      r_nq_idx     <= '0;
      r_nq_data    <= '0;
      r_error      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_value <= '0;
      r_resp_idx   <= '0;
      r_resp_ev    <= 1'b0;
      r_resp_ek    <= '0;
      r_resp_evv   <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (nq_crashed || r_state == S_ERROR) begin
        r_state  <= S_ERROR;
        r_error  <= 1'b1;
        r_enable <= 1'b0;
        r_cmd    <= NQ_NOP;
        r_wd     <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_wd <= '0;
            if (w_accept) begin
              r_op    <= req_op;
              r_key   <= req_key;
              r_value <= req_value;
              r_state <= S_CAM;
            end
          end
          S_CAM: begin
            r_wd <= '0;
            if (r_op) begin
              r_step    <= NQ_ENLIST;
              r_cmd     <= NQ_ENLIST;
              r_nq_idx  <= '0;
              r_nq_data <= {r_key, r_value};
              r_enable  <= 1'b1;
              r_state   <= S_ISSUE;
            end else if (w_match) begin
              r_lu_hit  <= 1'b1;
              r_hit_idx <= w_hit_idx;
              r_step    <= NQ_BACKOFQUEU;
              r_cmd     <= NQ_BACKOFQUEU;
              r_nq_idx  <= w_hit_idx;
              r_nq_data <= '0;
              r_enable  <= 1'b1;
              r_state   <= S_ISSUE;
            end else begin
              r_lu_hit <= 1'b0;
              r_state  <= S_RESPOND;
            end
          end
          S_ISSUE: begin
            if (nq_ready) begin
              r_ret_idx  <= nq_idx_ret;
              r_ret_data <= nq_data_ret;
              if (r_step == NQ_ENLIST) r_evict_v <= w_valid[nq_idx_ret];
              r_enable   <= 1'b0;
              r_cmd      <= NQ_NOP;
              r_wd       <= '0;
              r_state    <= S_RELEASE;
            end else if (r_wd == WD_LAST) begin
              r_state  <= S_ERROR;
              r_error  <= 1'b1;
              r_enable <= 1'b0;
              r_cmd    <= NQ_NOP;
              r_wd     <= '0;
            end else begin
              r_wd <= r_wd + 1'b1;
            end
          end
          S_RELEASE: begin
            if (!nq_ready) begin
              r_wd <= '0;
              if (r_step == NQ_BACKOFQUEU) begin
                r_step   <= NQ_READDATA;
                r_cmd    <= NQ_READDATA;
                r_nq_idx <= r_hit_idx;
                r_enable <= 1'b1;
                r_state  <= S_ISSUE;
              end else begin
                r_state <= S_RESPOND;
              end
            end else if (r_wd == WD_LAST) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
              r_wd    <= '0;
            end else begin
              r_wd <= r_wd + 1'b1;
            end
          end
          S_RESPOND: begin
            r_wd         <= '0;
            r_resp_valid <= 1'b1;
            if (r_op) begin
              r_resp_hit <= 1'b0;
              r_resp_idx <= r_ret_idx;
              r_resp_ev  <= r_evict_v;
              r_resp_ek  <= r_ret_data[KEY_MSB:KEY_LSB];
              r_resp_evv <= r_ret_data[VAL_MSB:0];
            end else begin
              r_resp_hit <= r_lu_hit;
              r_resp_ev  <= 1'b0;
              if (r_lu_hit) begin
                r_resp_idx   <= r_hit_idx;
                r_resp_value <= r_ret_data[VAL_MSB:0];
              end
            end
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign resp_valid       = r_resp_valid;
  assign resp_hit         = r_resp_hit;
  assign resp_value       = r_resp_value;
  assign resp_idx         = r_resp_idx;
  assign resp_evict_valid = r_resp_ev;
  assign resp_evict_key   = r_resp_ek;
  assign resp_evict_value = r_resp_evv;
  assign error            = r_error;
  assign nq_command       = r_cmd;
  assign nq_enable        = r_enable;
  assign nq_idx           = r_nq_idx;
  assign nq_data          = r_nq_data;

endmodule

// File: tb/tb_nq_lru_controller.sv
// Directed bench for nq_lru_controller with a NaughtyQ handshake responder and scoreboards.
module tb_nq_lru_controller;
  localparam int IW = 2;
  localparam int KW = 8;
  localparam int VW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_op = 1'b0;
  logic [KW-1:0] req_key = '0;
  logic [VW-1:0] req_value = '0;
  logic          resp_valid, resp_hit, resp_evict_valid, error, nq_enable;
  logic [VW-1:0] resp_value, resp_evict_value;
  logic [IW-1:0] resp_idx, nq_idx;
  logic [KW-1:0] resp_evict_key;
  logic [1:0]    nq_command;
  logic [KW+VW-1:0] nq_data;
  logic          nq_ready = 1'b0;
  logic          nq_crashed = 1'b0;
  logic [IW-1:0] nq_idx_ret = '0;
  logic [KW+VW-1:0] nq_data_ret = '0;
  logic          hold = 1'b0;

  int total = 0;
  int passed = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  cmd;
    logic [IW-1:0] idx;
    logic [15:0] data;
    logic        ci;
    logic        cd;
  } cmd_t;

  typedef struct {
    logic        hit;
    logic [7:0]  value;
    logic [IW-1:0] idx;
    logic        ev;
    logic [7:0]  ek;
    logic [7:0]  evv;
    logic        cv;
    logic        ci;
    logic        ck;
  } resp_t;

  cmd_t  cmdq[$];
  resp_t respq[$];

  nq_lru_controller #(
    .IDX_WIDTH(IW), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TIMEOUT(16)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_value(req_value),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_value(resp_value),
    .resp_idx(resp_idx), .resp_evict_valid(resp_evict_valid),
    .resp_evict_key(resp_evict_key), .resp_evict_value(resp_evict_value),
    .error(error), .nq_command(nq_command), .nq_enable(nq_enable),
    .nq_idx(nq_idx), .nq_data(nq_data), .nq_ready(nq_ready),
    .nq_crashed(nq_crashed), .nq_idx_ret(nq_idx_ret), .nq_data_ret(nq_data_ret)
  );

  always #5 clock = ~clock;

  // Queue responder: ready follows enable one cycle later, or stays low when held.
  always @(posedge clock) nq_ready <= (reset || hold) ? 1'b0 : nq_enable;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [1:0] c, input logic [IW-1:0] i, input logic [15:0] d,
                          input logic ci, input logic cd);
    cmd_t e;
    e.cmd = c; e.idx = i; e.data = d; e.ci = ci; e.cd = cd;
    cmdq.push_back(e);
  endtask

  task automatic push_resp(input logic h, input logic [7:0] v, input logic [IW-1:0] i,
                           input logic ev, input logic [7:0] ek, input logic [7:0] evv,
                           input logic cv, input logic ci, input logic ck);
    resp_t e;
    e.hit = h; e.value = v; e.idx = i; e.ev = ev; e.ek = ek; e.evv = evv;
    e.cv = cv; e.ci = ci; e.ck = ck;
    respq.push_back(e);
  endtask

  task automatic send(input logic op, input logic [7:0] k, input logic [7:0] v);
    int n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk("req_ready_before_send", 32'(req_ready), 1);
    req_valid = 1'b1; req_op = op; req_key = k; req_value = v;
    tick();
    req_valid = 1'b0;
  endtask

  // exp_lat >= 0 marks a miss: check latency and that the queue was never enabled.
  task automatic run_txn(input int exp_lat);
    int n = 0;
    logic prev = 1'b0;
    logic done = 1'b0;
    logic en_seen = 1'b0;
    cmd_t c;
    resp_t r;
    while (!done && n < 200) begin
      tick(); n++;
      if (nq_enable && !prev) begin
        en_seen = 1'b1;
        chk("cmd_expected", 32'(cmdq.size() > 0), 1);
        if (cmdq.size() > 0) begin
          c = cmdq.pop_front();
          chk("nq_command", 32'(nq_command), 32'(c.cmd));
          if (c.ci) chk("nq_idx", 32'(nq_idx), 32'(c.idx));
          if (c.cd) chk("nq_data", 32'(nq_data), 32'(c.data));
        end
      end
      prev = nq_enable;
      if (resp_valid) begin
        done = 1'b1;
        chk("resp_expected", 32'(respq.size() > 0), 1);
        if (respq.size() > 0) begin
          r = respq.pop_front();
          chk("resp_hit", 32'(resp_hit), 32'(r.hit));
          chk("resp_evict_valid", 32'(resp_evict_valid), 32'(r.ev));
          if (r.ci) chk("resp_idx", 32'(resp_idx), 32'(r.idx));
          if (r.cv) chk("resp_value", 32'(resp_value), 32'(r.value));
          if (r.ck) begin
            chk("resp_evict_key", 32'(resp_evict_key), 32'(r.ek));
            chk("resp_evict_value", 32'(resp_evict_value), 32'(r.evv));
          end
        end
        if (exp_lat >= 0) begin
          chk("miss_latency", 32'(n), 32'(exp_lat));
          chk("miss_no_enable", 32'(en_seen), 0);
        end
      end
    end
    chk("resp_seen", 32'(done), 1);
    chk("cmds_consumed", 32'(cmdq.size()), 0);
  endtask

  task automatic wait_enable();
    int n = 0;
    while (!nq_enable && n < 20) begin tick(); n++; end
    chk("enable_rose", 32'(nq_enable), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    logic sticky;
    logic any_resp;

    // Reset state
    tick(); tick();
    chk("reset_outputs", {resp_valid, resp_hit, resp_evict_valid, error, nq_enable,
                          nq_command, req_ready, resp_idx}, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 32'(req_ready), 1);

    // Lookup miss on an empty table
    push_resp(1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    send(1'b0, 8'h11, 8'h00);
    run_txn(2);

    // Insert 0x11/0xA1 into idx 3
    nq_idx_ret = 2'd3; nq_data_ret = 16'h0000;
    push_cmd(2'd1, 2'd0, 16'h11A1, 1'b0, 1'b1);
    push_resp(1'b0, 8'h00, 2'd3, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    send(1'b1, 8'h11, 8'hA1);
    run_txn(-1);

    // Lookup hit 0x11 at idx 3
    nq_data_ret = 16'h11A1;
    push_cmd(2'd2, 2'd3, 16'h0, 1'b1, 1'b0);
    push_cmd(2'd3, 2'd3, 16'h0, 1'b1, 1'b0);
    push_resp(1'b1, 8'hA1, 2'd3, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    send(1'b0, 8'h11, 8'h00);
    run_txn(-1);

    // Fill idx 2 with 0x12/0xC2, then displace it with 0x22/0xB2
    nq_idx_ret = 2'd2; nq_data_ret = 16'h0000;
    push_cmd(2'd1, 2'd0, 16'h12C2, 1'b0, 1'b1);
    push_resp(1'b0, 8'h00, 2'd2, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    send(1'b1, 8'h12, 8'hC2);
    run_txn(-1);

    nq_idx_ret = 2'd2; nq_data_ret = 16'h12C2;
    push_cmd(2'd1, 2'd0, 16'h22B2, 1'b0, 1'b1);
    push_resp(1'b0, 8'h00, 2'd2, 1'b1, 8'h12, 8'hC2, 1'b0, 1'b1, 1'b1);
    send(1'b1, 8'h22, 8'hB2);
    run_txn(-1);

    push_resp(1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    send(1'b0, 8'h12, 8'h00);
    run_txn(2);

    nq_data_ret = 16'h22B2;
    push_cmd(2'd2, 2'd2, 16'h0, 1'b1, 1'b0);
    push_cmd(2'd3, 2'd2, 16'h0, 1'b1, 1'b0);
    push_resp(1'b1, 8'hB2, 2'd2, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    send(1'b0, 8'h22, 8'h00);
    run_txn(-1);

    // Re-insert 0x11 with new value; the queue places it at idx 0
    nq_idx_ret = 2'd0; nq_data_ret = 16'h0000;
    push_cmd(2'd1, 2'd0, 16'h11EE, 1'b0, 1'b1);
    push_resp(1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    send(1'b1, 8'h11, 8'hEE);
    run_txn(-1);

    nq_data_ret = 16'h11EE;
    push_cmd(2'd2, 2'd0, 16'h0, 1'b1, 1'b0);
    push_cmd(2'd3, 2'd0, 16'h0, 1'b1, 1'b0);
    push_resp(1'b1, 8'hEE, 2'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    send(1'b0, 8'h11, 8'h00);
    run_txn(-1);

    // Watchdog: queue never answers
    hold = 1'b1;
    send(1'b0, 8'h22, 8'h00);
    wait_enable();
    chk("timeout_cmd", 32'(nq_command), 2);
    n = 0;
    while (!error && n < 40) begin tick(); n++; end
    chk("timeout_cycles", 32'(n), 16);
    chk("timeout_enable_low", 32'(nq_enable), 0);
    chk("timeout_not_ready", 32'(req_ready), 0);
    sticky = 1'b1; any_resp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      sticky &= error;
      any_resp |= resp_valid;
    end
    chk("timeout_sticky", 32'(sticky), 1);
    chk("timeout_no_resp", 32'(any_resp), 0);
    do_reset();
    hold = 1'b0;
    #1;
    chk("error_cleared", 32'(error), 0);

    // Crash indication while idle
    nq_crashed = 1'b1;
    tick();
    nq_crashed = 1'b0;
    chk("crash_error", 32'(error), 1);
    sticky = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); sticky &= error & ~req_ready; end
    chk("crash_sticky", 32'(sticky), 1);
    do_reset();

    // Reset in the middle of a hit sequence
    nq_idx_ret = 2'd1; nq_data_ret = 16'h0000;
    push_cmd(2'd1, 2'd0, 16'h33D3, 1'b0, 1'b1);
    push_resp(1'b0, 8'h00, 2'd1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    send(1'b1, 8'h33, 8'hD3);
    run_txn(-1);
    hold = 1'b1;
    send(1'b0, 8'h33, 8'h00);
    wait_enable();
    chk("midhit_idx", 32'(nq_idx), 1);
    reset = 1'b1;
    tick();
    chk("midhit_enable_dropped", 32'(nq_enable), 0);
    chk("midhit_no_resp", 32'(resp_valid), 0);
    reset = 1'b0;
    hold = 1'b0;
    any_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); any_resp |= resp_valid; end
    chk("midhit_idle", 32'(req_ready), 1);
    chk("midhit_dropped", 32'(any_resp), 0);
    push_resp(1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    send(1'b0, 8'h33, 8'h00);
    run_txn(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nq_lru_controller.md
Name: nq_lru_controller

Overview:
- Initiator (command master) for the NaughtyQ recency queue; turns it into a small key/value LRU cache.
- Holds a tag table mapping each queue index to a key.
- Serves lookup/insert requests from an upstream client by sequencing NaughtyQ commands (ENLIST, BACKOFQUEU, READDATA) over the queue's enable/ready handshake.
- Reports hits, values and evictions; sits between a flow-table client and one NaughtyQ instance.

Parameters:
- IDX_WIDTH, 3, queue index width; must equal the attached queue's IDX_WIDTH; entries N = 2**IDX_WIDTH.
- KEY_WIDTH, 8, key width.
- VALUE_WIDTH, 8, value width. Queue DATA_WIDTH = KEY_WIDTH+VALUE_WIDTH, key in MSBs.
- TIMEOUT, 16, max cycles waiting on any single ready edge before error.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts request this cycle.
- req_op  in  1  0=lookup, 1=insert.
- req_key  in  KEY_WIDTH  key.
- req_value  in  VALUE_WIDTH  insert value.
- resp_valid  out  1  one-cycle response pulse.
- resp_hit  out  1  lookup hit.
- resp_value  out  VALUE_WIDTH  value read on hit.
- resp_idx  out  IDX_WIDTH  queue index used.
- resp_evict_valid  out  1  insert displaced a valid entry.
- resp_evict_key  out  KEY_WIDTH  displaced key.
- resp_evict_value  out  VALUE_WIDTH  displaced value.
- error  out  1  sticky fault.
- nq_command  out  NQ_COMMAND_WIDTH+1  to queue command.
- nq_enable  out  1  to queue enable.
- nq_idx  out  IDX_WIDTH  to queue idx_in.
- nq_data  out  KEY_WIDTH+VALUE_WIDTH  to queue data_in.
- nq_ready  in  1  from queue.
- nq_crashed  in  1  from queue.
- nq_idx_ret  in  IDX_WIDTH  queue idx_out.
- nq_data_ret  in  KEY_WIDTH+VALUE_WIDTH  queue data_out.

Behaviour:
- Reset (sync): all outputs 0; tag valid bits cleared; state IDLE; watchdog 0. The queue shares the same reset.
- req_ready = (state==IDLE) && !error. Request is accepted on req_valid && req_ready and latched.
- Tag CAM: combinational compare of the latched key against all valid tags.
- Queue transaction (one per step): drive command/idx/data and set nq_enable=1 (ISSUE).
  - Hold until nq_ready=1, then latch nq_idx_ret/nq_data_ret and drop nq_enable.
  - RELEASE: wait for nq_ready=0 before issuing the next step or responding.
  - nq_enable is never re-raised while nq_ready=1.
- Lookup miss: no queue transaction; RESPOND next cycle with resp_hit=0.
- Lookup hit at index h: BACKOFQUEU(idx=h), then READDATA(idx=h). Respond with resp_hit=1, resp_idx=h, resp_value=low VALUE_WIDTH bits of the returned data.
- Insert: if the key is already present, clear that tag's valid bit first (same cycle as accept). Then ENLIST(data={key,value}).
  - Returned idx e: resp_evict_valid = old valid[e]; evict key/value are taken from the returned data.
  - Tag[e] := key, valid[e] := 1. Respond with resp_idx=e, resp_hit=0.
- States: IDLE, CAM, ISSUE, RELEASE, RESPOND, ERROR. Step register selects the command.
- Watchdog: counts cycles in ISSUE/RELEASE and clears on every state change. Reaching TIMEOUT goes to ERROR.
- nq_crashed=1 in any state goes to ERROR.
- ERROR: error=1, nq_enable=0, req_ready=0, no responses; exits only on reset.
- resp_* fields hold their values after the resp_valid pulse until the next response.
- Reset mid-transaction: nq_enable=0 the following cycle; the pending request is dropped with no response.
- Command codes: NOP=0, ENLIST=1, BACKOFQUEU=2, READDATA=3. No other codes are ever driven.

Decomposition:
- Shared package/header nq_defs:
  - NQ_COMMAND_WIDTH.
  - Command code constants (currently declared inside the queue; move them here).
  - Field-position macros for the {key,value} packing.
- Sub-module nq_tag_cam: valid bits plus key array.
  - Write port (idx, key, set/clear valid).
  - Combinational match/hit_idx output.
  - Priority: lowest index wins; multiple matches are impossible by construction.

Test Plan:
- Bench responder model: raises nq_ready 1 cycle after enable rises, lowers it 1 cycle after enable falls. IDX_WIDTH=2, KEY/VALUE=8, TIMEOUT=16.
- Reset, lookup key 0x11 -> resp_hit=0, nq_enable never asserted, resp_valid 2 cycles after accept.
- Insert 0x11/0xA1, responder returns idx 3, data 0x0000 -> nq_command=1 with nq_data=0x11A1; resp_idx=3; resp_evict_valid=0; subsequent lookup 0x11 issues command 2 (idx 3) then command 3 (idx 3); responder data 0x11A1 -> resp_hit=1, resp_value=0xA1.
- Insert 0x22/0xB2 with idx 2 holding valid key 0x12; responder returns idx 2, data 0x12C2 -> resp_evict_valid=1, evict_key=0x12, evict_value=0xC2; lookup 0x12 then misses.
- Insert existing key 0x11 with new value 0xEE -> old tag cleared, ENLIST issued; responder returns idx 0 -> lookup 0x11 hits idx 0 only.
- Responder holds nq_ready=0 -> error=1 exactly 16 cycles after enable rise; nq_enable=0, req_ready=0. Separately, pulse nq_crashed in IDLE -> error next cycle. Both stay sticky until reset.
- Assert reset while nq_enable=1 mid-hit -> next cycle nq_enable=0, state IDLE, all tags invalid, no resp_valid.
